// File: rtl/reg_arb_pkg.sv
// Shared types for the RegFile access arbiter.
// FSM state encodings and requester port indices.
package reg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2
    } arb_state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/arb_rr_pick.sv
// Two-way round-robin picker for the RegFile arbiter.
// A lone requester wins; on a tie the port that did not win last goes.
module arb_rr_pick
    import reg_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic       grant_idx_o,
    output logic       any_req_o
);

    assign any_req_o = |req_i;

    // Select the winning port index from the request pair and last-grant pointer.
    always_comb begin
        grant_idx_o = PORT0;
        unique case (req_i)
            2'b01:   grant_idx_o = PORT0;
            2'b10:   grant_idx_o = PORT1;
            2'b11:   grant_idx_o = ~ptr_i;
            default: grant_idx_o = PORT0;
        endcase
    end

endmodule

// File: rtl/reg_file_arbiter.sv
// Shares the single RegFile access port between SYS_CTRL (port 0) and a secondary master (port 1).
// Optional read-return timeout is compiled in with REG_ARB_TIMEOUT_EN.
module reg_file_arbiter
    import reg_arb_pkg::*;
#(
    parameter int ADDR_SIZE      = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                  CLK,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_SIZE-1:0]  addr0,
    input  logic [ADDR_SIZE-1:0]  addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic                  WrEn,
    output logic                  RdEn,
    output logic [ADDR_SIZE-1:0]  Address,
    output logic [DATA_WIDTH-1:0] WrData,
    input  logic [DATA_WIDTH-1:0] Rd_Data,
    input  logic                  Rd_Data_VLD,
    output logic                  arb_busy,
    output logic                  rd_timeout
);

    arb_state_t            state_q;
    logic                  ptr_q;
    logic                  owner_q;
    logic                  we_q;
    logic [ADDR_SIZE-1:0]  addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  gnt0_q;
    logic                  gnt1_q;
    logic                  wr_en_q;
    logic                  rd_en_q;
    logic                  rvalid0_q;
    logic                  rvalid1_q;
    logic [DATA_WIDTH-1:0] rdata0_q;
    logic [DATA_WIDTH-1:0] rdata1_q;

    logic                  win_idx;
    logic                  any_req;
    logic                  win_we_d;
    logic [ADDR_SIZE-1:0]  win_addr_d;
    logic [DATA_WIDTH-1:0] win_wdata_d;

    arb_rr_pick u_pick (
        .req_i       ({req1, req0}),
        .ptr_i       (ptr_q),
        .grant_idx_o (win_idx),
        .any_req_o   (any_req)
    );

    // Command fields of whichever port the picker selected.
    always_comb begin
        win_we_d    = (win_idx == PORT1) ? we1    : we0;
        win_addr_d  = (win_idx == PORT1) ? addr1  : addr0;
        win_wdata_d = (win_idx == PORT1) ? wdata1 : wdata0;
    end

`ifdef REG_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             rd_timeout_q;
`endif

    // Arbitration FSM; all strobes and return data are registered here.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= PORT1;
            owner_q   <= PORT0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
`ifdef REG_ARB_TIMEOUT_EN
            cnt_q        <= '0;
            rd_timeout_q <= 1'b0;
`endif
        end else begin
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
`ifdef REG_ARB_TIMEOUT_EN
            rd_timeout_q <= 1'b0;
`endif
            unique case (state_q)
                IDLE: begin
                    if (any_req) begin
                        owner_q <= win_idx;
                        ptr_q   <= win_idx;
                        we_q    <= win_we_d;
                        addr_q  <= win_addr_d;
                        wdata_q <= win_wdata_d;
                        wr_en_q <= win_we_d;
                        rd_en_q <= ~win_we_d;
                        gnt0_q  <= (win_idx == PORT0);
                        gnt1_q  <= (win_idx == PORT1);
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    state_q <= we_q ? IDLE : WAIT_RD;
`ifdef REG_ARB_TIMEOUT_EN
                    cnt_q <= '0;
`endif
                end
                WAIT_RD: begin
                    if (Rd_Data_VLD) begin
                        if (owner_q == PORT1) begin
                            rdata1_q  <= Rd_Data;
                            rvalid1_q <= 1'b1;
                        end else begin
                            rdata0_q  <= Rd_Data;
                            rvalid0_q <= 1'b1;
                        end
                        state_q <= IDLE;
                    end
`ifdef REG_ARB_TIMEOUT_EN
                    else if (cnt_q == CNT_LAST) begin
                        if (owner_q == PORT1) begin
                            rdata1_q  <= '0;
                            rvalid1_q <= 1'b1;
                        end else begin
                            rdata0_q  <= '0;
                            rvalid0_q <= 1'b1;
                        end
                        rd_timeout_q <= 1'b1;
                        state_q      <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt0     = gnt0_q;
    assign gnt1     = gnt1_q;
    assign WrEn     = wr_en_q;
    assign RdEn     = rd_en_q;
    assign Address  = addr_q;
    assign WrData   = wdata_q;
    assign rvalid0  = rvalid0_q;
    assign rvalid1  = rvalid1_q;
    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;
    assign arb_busy = (state_q != IDLE);

`ifdef REG_ARB_TIMEOUT_EN
    assign rd_timeout = rd_timeout_q;
`else
    assign rd_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_reg_file_arbiter.sv
// Self-checking bench for reg_file_arbiter.
// Directed scenarios plus randomized traffic against a transaction-level model.
module tb_reg_file_arbiter;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int TO = 15;

    logic          CLK = 1'b0;
    logic          rst_n;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1;
    logic [DW-1:0] rdata0, rdata1;
    logic          rvalid0, rvalid1;
    logic          WrEn, RdEn;
    logic [AW-1:0] Address;
    logic [DW-1:0] WrData;
    logic [DW-1:0] Rd_Data;
    logic          Rd_Data_VLD;
    logic          arb_busy, rd_timeout;

    int checks = 0;
    int failures = 0;

    // Model state: port that won most recently (1 after reset so port 0 wins first tie)
    logic          last_win;
    logic [DW-1:0] mem [16];

    reg_file_arbiter #(
        .ADDR_SIZE      (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .CLK         (CLK),
        .rst_n       (rst_n),
        .req0        (req0),
        .req1        (req1),
        .we0         (we0),
        .we1         (we1),
        .addr0       (addr0),
        .addr1       (addr1),
        .wdata0      (wdata0),
        .wdata1      (wdata1),
        .gnt0        (gnt0),
        .gnt1        (gnt1),
        .rdata0      (rdata0),
        .rdata1      (rdata1),
        .rvalid0     (rvalid0),
        .rvalid1     (rvalid1),
        .WrEn        (WrEn),
        .RdEn        (RdEn),
        .Address     (Address),
        .WrData      (WrData),
        .Rd_Data     (Rd_Data),
        .Rd_Data_VLD (Rd_Data_VLD),
        .arb_busy    (arb_busy),
        .rd_timeout  (rd_timeout)
    );

    always #5 CLK = ~CLK;

    task automatic wait_gnt(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (gnt0 || gnt1) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge CLK); #1;
        rst_n = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        rst_n = 1'b1;
        last_win = 1'b1;
    endtask

    task automatic test_reset();
        logic [7:0] outs;
        rst_n = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        we0 = 1'b1; we1 = 1'b0;
        addr0 = 4'h5; addr1 = 4'hA;
        wdata0 = 8'h11; wdata1 = 8'h22;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            outs = {gnt0, gnt1, WrEn, RdEn, rvalid0, rvalid1, arb_busy, rd_timeout};
            checks++;
            if (outs !== 8'h00 || Address !== '0 || WrData !== '0 ||
                rdata0 !== '0 || rdata1 !== '0) begin
                failures++;
                $display("FAIL reset cyc%0d: strobes=%b addr=%h wd=%h rd0=%h rd1=%h, want all 0",
                         i, outs, Address, WrData, rdata0, rdata1);
            end
        end
        @(posedge CLK); #1;
        req0 = 1'b0; req1 = 1'b0;
        rst_n = 1'b1;
        last_win = 1'b1;
    endtask

    task automatic test_single_write();
        @(posedge CLK); #1;
        req0 = 1'b1; we0 = 1'b1; addr0 = 4'h2; wdata0 = 8'hA5;
        @(negedge CLK);
        checks++;
        if (gnt0 !== 1'b0 || WrEn !== 1'b0) begin
            failures++;
            $display("FAIL write_early: gnt0=%b WrEn=%b, want 0 0", gnt0, WrEn);
        end
        @(negedge CLK);
        checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || WrEn !== 1'b1 || RdEn !== 1'b0 ||
            Address !== 4'h2 || WrData !== 8'hA5 || arb_busy !== 1'b1) begin
            failures++;
            $display("FAIL write_issue: gnt=%b%b we=%b re=%b a=%h d=%h busy=%b, want 01 1 0 2 a5 1",
                     gnt1, gnt0, WrEn, RdEn, Address, WrData, arb_busy);
        end
        last_win = 1'b0;
        mem[2] = 8'hA5;
        @(posedge CLK); #1;
        req0 = 1'b0;
        @(negedge CLK);
        checks++;
        if (arb_busy !== 1'b0 || WrEn !== 1'b0 || gnt0 !== 1'b0) begin
            failures++;
            $display("FAIL write_done: busy=%b WrEn=%b gnt0=%b, want 0 0 0",
                     arb_busy, WrEn, gnt0);
        end
    endtask

    task automatic test_contention();
        int   seen;
        logic exp;
        do_reset();
        req0 = 1'b1; we0 = 1'b1; addr0 = 4'h1; wdata0 = 8'h10;
        req1 = 1'b1; we1 = 1'b1; addr1 = 4'h9; wdata1 = 8'h90;
        seen = 0;
        for (int i = 0; i < 20 && seen < 4; i++) begin
            @(negedge CLK);
            checks++;
            if (gnt0 && gnt1) begin
                failures++;
                $display("FAIL contend_both: gnt0=%b gnt1=%b, want not both", gnt0, gnt1);
            end
            if (gnt0 || gnt1) begin
                exp = ~last_win;
                checks++;
                if ({gnt1, gnt0} !== (exp ? 2'b10 : 2'b01)) begin
                    failures++;
                    $display("FAIL contend_order #%0d: gnt=%b%b, want port %0d",
                             seen, gnt1, gnt0, exp);
                end
                last_win = exp;
                seen++;
            end
        end
        checks++;
        if (seen != 4) begin
            failures++;
            $display("FAIL contend_count: grants=%0d, want 4", seen);
        end
        mem[1] = 8'h10;
        mem[9] = 8'h90;
        @(posedge CLK); #1;
        req0 = 1'b0; req1 = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic test_read_routing();
        bit got;
        @(posedge CLK); #1;
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'h3;
        wait_gnt(5, got);
        checks++;
        if (!got || gnt1 !== 1'b1 || gnt0 !== 1'b0 || RdEn !== 1'b1 ||
            WrEn !== 1'b0 || Address !== 4'h3) begin
            failures++;
            $display("FAIL read_issue: got=%0d gnt=%b%b re=%b we=%b a=%h, want 1 10 1 0 3",
                     got, gnt1, gnt0, RdEn, WrEn, Address);
        end
        last_win = 1'b1;
        @(posedge CLK); #1;
        req1 = 1'b0;
        Rd_Data_VLD = 1'b1; Rd_Data = 8'h3C;
        @(posedge CLK); #1;
        Rd_Data_VLD = 1'b0; Rd_Data = 8'hFF;
        @(negedge CLK);
        checks++;
        if (rvalid1 !== 1'b1 || rdata1 !== 8'h3C || rvalid0 !== 1'b0) begin
            failures++;
            $display("FAIL read_return: rv1=%b rd1=%h rv0=%b, want 1 3c 0",
                     rvalid1, rdata1, rvalid0);
        end
        @(negedge CLK);
        checks++;
        if (rvalid1 !== 1'b0 || rdata1 !== 8'h3C) begin
            failures++;
            $display("FAIL read_hold: rv1=%b rd1=%h, want 0 3c", rvalid1, rdata1);
        end
    endtask

    task automatic test_stray_and_reset();
        bit got;
        @(posedge CLK); #1;
        Rd_Data_VLD = 1'b1; Rd_Data = 8'h77;
        @(posedge CLK); #1;
        Rd_Data_VLD = 1'b0;
        @(negedge CLK);
        checks++;
        if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0 || arb_busy !== 1'b0) begin
            failures++;
            $display("FAIL stray_vld: rv0=%b rv1=%b busy=%b, want 0 0 0",
                     rvalid0, rvalid1, arb_busy);
        end
        @(posedge CLK); #1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'h5;
        wait_gnt(5, got);
        checks++;
        if (!got || gnt0 !== 1'b1) begin
            failures++;
            $display("FAIL midrst_gnt: got=%0d gnt0=%b, want 1 1", got, gnt0);
        end
        @(posedge CLK); #1;
        req0 = 1'b0;
        @(negedge CLK);
        checks++;
        if (arb_busy !== 1'b1) begin
            failures++;
            $display("FAIL midrst_wait: busy=%b, want 1", arb_busy);
        end
        @(posedge CLK); #1;
        rst_n = 1'b0;
        @(posedge CLK); #1;
        rst_n = 1'b1;
        last_win = 1'b1;
        Rd_Data_VLD = 1'b1; Rd_Data = 8'h99;
        @(posedge CLK); #1;
        Rd_Data_VLD = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            checks++;
            if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0 || arb_busy !== 1'b0 ||
                rdata0 !== '0) begin
                failures++;
                $display("FAIL midrst_after%0d: rv0=%b rv1=%b busy=%b rd0=%h, want 0 0 0 00",
                         i, rvalid0, rvalid1, arb_busy, rdata0);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0]    pend;
        logic [1:0]    c_we;
        logic [AW-1:0] c_addr [2];
        logic [DW-1:0] c_wd [2];
        logic          exp;
        logic [DW-1:0] want;
        bit            got;
        int            d;
        for (int it = 0; it < 40; it++) begin
            @(posedge CLK); #1;
            pend = 2'($urandom_range(1, 3));
            for (int p = 0; p < 2; p++) begin
                c_we[p]   = 1'($urandom_range(0, 1));
                c_addr[p] = AW'($urandom_range(0, 15));
                c_wd[p]   = DW'($urandom);
            end
            req0 = pend[0]; we0 = c_we[0]; addr0 = c_addr[0]; wdata0 = c_wd[0];
            req1 = pend[1]; we1 = c_we[1]; addr1 = c_addr[1]; wdata1 = c_wd[1];
            while (pend != 2'b00) begin
                exp = (pend == 2'b11) ? ~last_win : pend[1];
                wait_gnt(8, got);
                checks++;
                if (!got) begin
                    failures++;
                    $display("FAIL rnd_timeout it%0d: no gnt, want port %0d", it, exp);
                    req0 = 1'b0; req1 = 1'b0;
                    break;
                end
                checks++;
                if ({gnt1, gnt0} !== (exp ? 2'b10 : 2'b01)) begin
                    failures++;
                    $display("FAIL rnd_gnt it%0d: gnt=%b%b, want port %0d",
                             it, gnt1, gnt0, exp);
                end
                checks++;
                if (WrEn !== c_we[exp] || RdEn !== ~c_we[exp] ||
                    Address !== c_addr[exp] ||
                    (c_we[exp] && WrData !== c_wd[exp])) begin
                    failures++;
                    $display("FAIL rnd_cmd it%0d: we=%b re=%b a=%h d=%h, want we=%b a=%h d=%h",
                             it, WrEn, RdEn, Address, WrData,
                             c_we[exp], c_addr[exp], c_wd[exp]);
                end
                last_win = exp;
                pend[exp] = 1'b0;
                @(posedge CLK); #1;
                if (exp) req1 = 1'b0;
                else req0 = 1'b0;
                if (c_we[exp]) begin
                    mem[c_addr[exp]] = c_wd[exp];
                end else begin
                    want = mem[c_addr[exp]];
                    d = $urandom_range(0, 2);
                    repeat (d) begin
                        @(posedge CLK); #1;
                    end
                    Rd_Data = want; Rd_Data_VLD = 1'b1;
                    @(posedge CLK); #1;
                    Rd_Data_VLD = 1'b0; Rd_Data = DW'($urandom);
                    @(negedge CLK);
                    checks++;
                    if ((exp && (rvalid1 !== 1'b1 || rdata1 !== want || rvalid0 !== 1'b0)) ||
                        (!exp && (rvalid0 !== 1'b1 || rdata0 !== want || rvalid1 !== 1'b0))) begin
                        failures++;
                        $display("FAIL rnd_rd it%0d: rv=%b%b rd0=%h rd1=%h, want port %0d data %h",
                                 it, rvalid1, rvalid0, rdata0, rdata1, exp, want);
                    end
                end
            end
        end
        @(posedge CLK); #1;
    endtask

`ifdef REG_ARB_TIMEOUT_EN
    task automatic test_timeout();
        bit got;
        int first;
        @(posedge CLK); #1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'h7;
        wait_gnt(5, got);
        checks++;
        if (!got || gnt0 !== 1'b1) begin
            failures++;
            $display("FAIL to_gnt: got=%0d gnt0=%b, want 1 1", got, gnt0);
        end
        last_win = 1'b0;
        @(posedge CLK); #1;
        req0 = 1'b0;
        Rd_Data_VLD = 1'b1; Rd_Data = 8'h5A;
        @(posedge CLK); #1;
        Rd_Data_VLD = 1'b0;
        @(negedge CLK);
        checks++;
        if (rvalid0 !== 1'b1 || rdata0 !== 8'h5A) begin
            failures++;
            $display("FAIL to_prime: rv0=%b rd0=%h, want 1 5a", rvalid0, rdata0);
        end
        @(posedge CLK); #1;
        req0 = 1'b1;
        wait_gnt(5, got);
        @(posedge CLK); #1;
        req0 = 1'b0;
        first = 0;
        for (int i = 1; i <= TO + 5; i++) begin
            @(negedge CLK);
            if (rvalid0 && first == 0) begin
                first = i;
                checks++;
                if (rd_timeout !== 1'b1 || rdata0 !== '0 || rvalid1 !== 1'b0) begin
                    failures++;
                    $display("FAIL to_pulse: to=%b rd0=%h rv1=%b, want 1 00 0",
                             rd_timeout, rdata0, rvalid1);
                end
            end
        end
        checks++;
        if (first != TO + 1) begin
            failures++;
            $display("FAIL to_latency: rvalid0 at cycle %0d, want %0d", first, TO + 1);
        end
        @(posedge CLK); #1;
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'h8;
        wait_gnt(5, got);
        checks++;
        if (!got || gnt1 !== 1'b1) begin
            failures++;
            $display("FAIL to_next: got=%0d gnt1=%b, want 1 1", got, gnt1);
        end
        last_win = 1'b1;
        @(posedge CLK); #1;
        req1 = 1'b0;
        repeat (TO - 1) begin
            @(posedge CLK); #1;
        end
        Rd_Data_VLD = 1'b1; Rd_Data = 8'hC3;
        @(posedge CLK); #1;
        Rd_Data_VLD = 1'b0;
        @(negedge CLK);
        checks++;
        if (rvalid1 !== 1'b1 || rdata1 !== 8'hC3 || rd_timeout !== 1'b0) begin
            failures++;
            $display("FAIL to_edge: rv1=%b rd1=%h to=%b, want 1 c3 0",
                     rvalid1, rdata1, rd_timeout);
        end
    endtask
`else
    task automatic test_no_timeout();
        bit got;
        int seen;
        @(posedge CLK); #1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'h7;
        wait_gnt(5, got);
        checks++;
        if (!got || gnt0 !== 1'b1) begin
            failures++;
            $display("FAIL nto_gnt: got=%0d gnt0=%b, want 1 1", got, gnt0);
        end
        last_win = 1'b0;
        @(posedge CLK); #1;
        req0 = 1'b0;
        seen = 0;
        for (int i = 0; i < TO + 10; i++) begin
            @(negedge CLK);
            if (rvalid0 || rvalid1 || rd_timeout || !arb_busy) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL nto_wait: %0d early-exit cycles, want 0", seen);
        end
        @(posedge CLK); #1;
        Rd_Data_VLD = 1'b1; Rd_Data = 8'h6E;
        @(posedge CLK); #1;
        Rd_Data_VLD = 1'b0;
        @(negedge CLK);
        checks++;
        if (rvalid0 !== 1'b1 || rdata0 !== 8'h6E || rd_timeout !== 1'b0) begin
            failures++;
            $display("FAIL nto_return: rv0=%b rd0=%h to=%b, want 1 6e 0",
                     rvalid0, rdata0, rd_timeout);
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0;
        wdata0 = '0; wdata1 = '0;
        Rd_Data = '0; Rd_Data_VLD = 1'b0;
        last_win = 1'b1;
        for (int i = 0; i < 16; i++) mem[i] = DW'(8'h40 + i);
        test_reset();
        test_single_write();
        test_contention();
        test_read_routing();
        test_stray_and_reset();
        test_random();
`ifdef REG_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
